disp_rd_scheduler: RTL and testbench
====================================

Name: disp_rd_scheduler

Overview:
Schedules SDRAM read bursts that keep the RGB565 display FIFO filled for the 1024x720 active window of the VGA output path. Tracks frame read address and remaining words, and requests fixed-length bursts from the SDRAM arbiter whenever the FIFO has room. Flushes and re-arms the FIFO at each frame start. Counts FIFO underflows seen by the pixel side.

Parameters:
H_ACTIVE, 1024, active pixels per line (one 16-bit word each)
V_ACTIVE, 720, active lines per frame
BURST_LEN, 256, max words per SDRAM read burst (power of two)
FIFO_DEPTH, 1024, display FIFO depth in words
ADDR_W, 22, SDRAM word-address width
FRAME_BASE, 0, word address of frame buffer 0

Ports:
CLK  in  1  system clock (same domain as FIFO write side)
RSTn  in  1  reset
frame_start  in  1  one-cycle pulse at start of vertical blank
fifo_wr_cnt  in  11  words currently held in display FIFO (write-side count)
fifo_rd  in  1  pixel-side FIFO read strobe
fifo_empty  in  1  FIFO empty flag
fifo_flush  out  1  one-cycle FIFO clear
rd_req  out  1  burst request to SDRAM arbiter
rd_addr  out  ADDR_W  burst start word address
rd_len  out  9  burst length in words, 1..BURST_LEN
rd_ack  in  1  arbiter accepted request (one-cycle)
rd_done  in  1  burst fully written into FIFO (one-cycle)
busy  out  1  high in every state except IDLE and FRAME_DONE
underflow_cnt  out  16  saturating count of reads while empty

Behaviour:
- Reset: RSTn is synchronous, active-low, clock CLK. State IDLE; fifo_flush, rd_req, busy = 0; rd_addr = 0; rd_len = 0; underflow_cnt = 0; pending_start = 0.
- Internal: words_left, 20 bits; frame size H_ACTIVE*V_ACTIVE = 737280.
- IDLE: frame_start -> FLUSH.
- FLUSH, 1 cycle: fifo_flush = 1; rd_addr <= base; words_left <= 737280; -> CHECK.
- CHECK: words_left == 0 -> FRAME_DONE. Else if fifo_wr_cnt <= FIFO_DEPTH - BURST_LEN -> REQ, with rd_len <= min(BURST_LEN, words_left). Else stay.
- REQ: rd_req = 1. rd_addr and rd_len hold stable until rd_ack. On rd_ack, rd_req drops the same edge -> WAIT_DONE.
- WAIT_DONE: on rd_done, rd_addr += rd_len, wrapping mod 2^ADDR_W; words_left -= rd_len; -> CHECK.
- FRAME_DONE: wait; frame_start -> FLUSH.
- Only one burst is outstanding at a time. Request-to-request latency is at least 2 cycles after rd_done.
- frame_start in CHECK or REQ: abort immediately -> FLUSH. rd_req deasserts the next cycle; an rd_ack coinciding with frame_start is ignored and the arbiter must cancel.
- frame_start in WAIT_DONE: set pending_start. On rd_done go to FLUSH, not CHECK, so the in-flight burst is never orphaned.
- frame_start coinciding with rd_done in WAIT_DONE -> FLUSH.
- Last burst: the default frame is 2880 full bursts. Non-multiple frame sizes end with a short burst of rd_len = words_left.
- Underflow: fifo_rd && fifo_empty -> underflow_cnt += 1, saturating at 0xFFFF. Not cleared by frame_start; cleared only by reset.
- fifo_wr_cnt is trusted as a count already synchronized to CLK. No prefetch of credit for in-flight data is needed, because bursts are serialized.

Optional Feature:
DISP_DOUBLE_BUFFER_EN
- With: extra input wr_frame_done, a one-cycle pulse from the camera writer. It sets a sticky new_frame flag. At frame_start, if new_frame is set, toggle rd_buf_sel and clear new_frame. base = rd_buf_sel ? FRAME_BASE + 2^20 : FRAME_BASE. rd_buf_sel is also a 1-bit output so the writer can target the other buffer. Reset: rd_buf_sel = 0, new_frame = 0.
- Without: base is always FRAME_BASE. The wr_frame_done and rd_buf_sel ports are absent.

Decomposition:
- Shared package disp_pkg: H_ACTIVE, V_ACTIVE, FRAME_WORDS, BURST_LEN defaults, RGB565 field positions, and the state enum IDLE/FLUSH/CHECK/REQ/WAIT_DONE/FRAME_DONE. These are shared with the VGA control and camera write blocks.
- One natural sub-module: disp_underflow_mon, a 16-bit saturating event counter.

Test Plan:
- Reset then frame_start; arbiter acks in 1 cycle and gives rd_done 20 cycles after ack; fifo_wr_cnt modelled -> 2880 bursts with rd_len = 256, addresses 0, 256, ... 737024, then FRAME_DONE and busy = 0.
- Hold fifo_wr_cnt = 769 -> no rd_req. Drop it to 768 -> rd_req on the next cycle after CHECK.
- Set V_ACTIVE = 3 and H_ACTIVE = 100 (300 words) -> bursts of 256 then 44, end address 300.
- frame_start in REQ before ack -> rd_req low next cycle, fifo_flush pulse, rd_addr = 0. frame_start in WAIT_DONE -> no flush until rd_done, then FLUSH.
- 3 cycles of fifo_rd with fifo_empty -> underflow_cnt = 3. Force it to 0xFFFF, then one more event -> stays 0xFFFF.
- DISP_DOUBLE_BUFFER_EN: wr_frame_done, then frame_start -> first rd_addr = 0x100000. A second frame_start without wr_frame_done -> rd_addr = 0x100000 again.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared display-path definitions: frame geometry defaults, RGB565 layout
// and the read-scheduler state encoding.
package disp_pkg;

  localparam int DISP_H_ACTIVE    = 1024;
  localparam int DISP_V_ACTIVE    = 720;
  localparam int DISP_FRAME_WORDS = DISP_H_ACTIVE * DISP_V_ACTIVE;
  localparam int DISP_BURST_LEN   = 256;
  localparam int DISP_FIFO_DEPTH  = 1024;

  localparam int RGB_R_MSB = 15;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    CHECK,
    REQ,
    WAIT_DONE,
    FRAME_DONE
  } disp_state_e;

endpackage

// File: rtl/disp_rd_scheduler_if.sv
// Burst request/acknowledge bus between the display read scheduler and the
// SDRAM arbiter.
interface disp_rd_scheduler_if #(
  parameter int ADDR_W = 22
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [8:0]        rd_len;
  logic              rd_ack;
  logic              rd_done;

  modport master (output rd_req, rd_addr, rd_len, input rd_ack, rd_done);
  modport slave  (input rd_req, rd_addr, rd_len, output rd_ack, rd_done);
endinterface

// File: rtl/disp_underflow_mon.sv
// Saturating event counter used to tally pixel-side FIFO underflows.
module disp_underflow_mon #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             evt,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (evt && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/disp_rd_scheduler.sv
// Display FIFO refill scheduler: one SDRAM read burst in flight at a time.
// Define DISP_DOUBLE_BUFFER_EN to add reader/writer frame-buffer ping-pong.
module disp_rd_scheduler
  import disp_pkg::*;
#(
  parameter int H_ACTIVE   = DISP_H_ACTIVE,
  parameter int V_ACTIVE   = DISP_V_ACTIVE,
  parameter int BURST_LEN  = DISP_BURST_LEN,
  parameter int FIFO_DEPTH = DISP_FIFO_DEPTH,
  parameter int ADDR_W     = 22,
  parameter int FRAME_BASE = 0
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  frame_start,
  input  logic [10:0]           fifo_wr_cnt,
  input  logic                  fifo_rd,
  input  logic                  fifo_empty,
  output logic                  fifo_flush,
  disp_rd_scheduler_if.master   rd_bus,
  output logic                  busy,
  output logic [15:0]           underflow_cnt
`ifdef DISP_DOUBLE_BUFFER_EN
  ,
  input  logic                  wr_frame_done,
  output logic                  rd_buf_sel
`endif
);

  localparam logic [19:0] FRAME_WORDS_L = 20'(H_ACTIVE * V_ACTIVE);
  localparam logic [19:0] BURST_W       = 20'(BURST_LEN);
  localparam logic [10:0] CREDIT_THR    = 11'(FIFO_DEPTH - BURST_LEN);

  disp_state_e       state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [8:0]        rd_len_q, rd_len_d;
  logic [19:0]       words_left_q, words_left_d;
  logic              pending_start_q, pending_start_d;
  logic              fifo_flush_q, fifo_flush_d;
  logic              rd_req_q, rd_req_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] base;

`ifdef DISP_DOUBLE_BUFFER_EN
  logic rd_buf_sel_q, rd_buf_sel_d;
  logic new_frame_q, new_frame_d;

  // A writer pulse landing on the same cycle as frame_start stays pending
  // for the following frame.
  always_comb begin
    rd_buf_sel_d = rd_buf_sel_q;
    new_frame_d  = new_frame_q | wr_frame_done;
    if (frame_start && new_frame_q) begin
      rd_buf_sel_d = ~rd_buf_sel_q;
      new_frame_d  = wr_frame_done;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      rd_buf_sel_q <= 1'b0;
      new_frame_q  <= 1'b0;
    end else begin
      rd_buf_sel_q <= rd_buf_sel_d;
      new_frame_q  <= new_frame_d;
    end
  end

  assign base       = rd_buf_sel_q ? ADDR_W'(FRAME_BASE + (1 << 20)) : ADDR_W'(FRAME_BASE);
  assign rd_buf_sel = rd_buf_sel_q;
`else
  assign base = ADDR_W'(FRAME_BASE);
`endif

  always_comb begin
    state_d         = state_q;
    rd_addr_d       = rd_addr_q;
    rd_len_d        = rd_len_q;
    words_left_d    = words_left_q;
    pending_start_d = pending_start_q;
    case (state_q)
      IDLE, FRAME_DONE: begin
        if (frame_start) state_d = FLUSH;
      end
      FLUSH: begin
        rd_addr_d    = base;
        words_left_d = FRAME_WORDS_L;
        state_d      = CHECK;
      end
      CHECK: begin
        if (frame_start)
          state_d = FLUSH;
        else if (words_left_q == '0)
          state_d = FRAME_DONE;
        else if (fifo_wr_cnt <= CREDIT_THR) begin
          state_d  = REQ;
          rd_len_d = (words_left_q >= BURST_W) ? 9'(BURST_LEN) : words_left_q[8:0];
        end
      end
      REQ: begin
        // An ack coinciding with frame_start is dropped; the arbiter cancels.
        if (frame_start)
          state_d = FLUSH;
        else if (rd_bus.rd_ack)
          state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (rd_bus.rd_done) begin
          rd_addr_d       = rd_addr_q + ADDR_W'(rd_len_q);
          words_left_d    = words_left_q - {11'd0, rd_len_q};
          state_d         = (pending_start_q || frame_start) ? FLUSH : CHECK;
          pending_start_d = 1'b0;
        end else if (frame_start) begin
          pending_start_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    fifo_flush_d = (state_d == FLUSH);
    rd_req_d     = (state_d == REQ);
    busy_d       = !(state_d inside {IDLE, FRAME_DONE});
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q         <= IDLE;
      rd_addr_q       <= '0;
      rd_len_q        <= '0;
      words_left_q    <= '0;
      pending_start_q <= 1'b0;
      fifo_flush_q    <= 1'b0;
      rd_req_q        <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      rd_addr_q       <= rd_addr_d;
      rd_len_q        <= rd_len_d;
      words_left_q    <= words_left_d;
      pending_start_q <= pending_start_d;
      fifo_flush_q    <= fifo_flush_d;
      rd_req_q        <= rd_req_d;
      busy_q          <= busy_d;
    end
  end

  disp_underflow_mon #(.CNT_W(16)) u_underflow_mon (
    .CLK  (CLK),
    .RSTn (RSTn),
    .evt  (fifo_rd & fifo_empty),
    .cnt  (underflow_cnt)
  );

  assign fifo_flush     = fifo_flush_q;
  assign busy           = busy_q;
  assign rd_bus.rd_req  = rd_req_q;
  assign rd_bus.rd_addr = rd_addr_q;
  assign rd_bus.rd_len  = rd_len_q;

endmodule

// File: tb/tb_disp_rd_scheduler.sv
// Directed bench: vector table on the full-size scheduler plus hand sequences
// for the full frame, a 300-word frame, counter saturation and double buffering.
module tb_disp_rd_scheduler;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  // full-size instance
  logic        RSTn = 1'b0, frame_start = 1'b0, fifo_rd = 1'b0, fifo_empty = 1'b0;
  logic [10:0] fifo_wr_cnt = '0;
  logic        fifo_flush, busy;
  logic [15:0] underflow_cnt;
  disp_rd_scheduler_if #(.ADDR_W(22)) bus ();

  // 100x3 instance
  logic        RSTn_s = 1'b0, frame_start_s = 1'b0, fifo_rd_s = 1'b0, fifo_empty_s = 1'b0;
  logic [10:0] fifo_wr_cnt_s = '0;
  logic        fifo_flush_s, busy_s;
  logic [15:0] underflow_cnt_s;
  disp_rd_scheduler_if #(.ADDR_W(22)) bus_s ();

`ifdef DISP_DOUBLE_BUFFER_EN
  logic wr_frame_done = 1'b0, wr_frame_done_s = 1'b0;
  logic rd_buf_sel, rd_buf_sel_s;
`endif

  disp_rd_scheduler dut (
    .CLK(CLK), .RSTn(RSTn), .frame_start(frame_start), .fifo_wr_cnt(fifo_wr_cnt),
    .fifo_rd(fifo_rd), .fifo_empty(fifo_empty), .fifo_flush(fifo_flush),
    .rd_bus(bus), .busy(busy), .underflow_cnt(underflow_cnt)
`ifdef DISP_DOUBLE_BUFFER_EN
    , .wr_frame_done(wr_frame_done), .rd_buf_sel(rd_buf_sel)
`endif
  );

  disp_rd_scheduler #(.H_ACTIVE(100), .V_ACTIVE(3)) dut_s (
    .CLK(CLK), .RSTn(RSTn_s), .frame_start(frame_start_s), .fifo_wr_cnt(fifo_wr_cnt_s),
    .fifo_rd(fifo_rd_s), .fifo_empty(fifo_empty_s), .fifo_flush(fifo_flush_s),
    .rd_bus(bus_s), .busy(busy_s), .underflow_cnt(underflow_cnt_s)
`ifdef DISP_DOUBLE_BUFFER_EN
    , .wr_frame_done(wr_frame_done_s), .rd_buf_sel(rd_buf_sel_s)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic        rstn, fs;
    logic [10:0] cnt;
    logic        rd, empty, ack, done;
    logic        flush, req, bsy;
    logic [21:0] addr;
    logic [8:0]  len;
    logic [15:0] ucnt;
  } vec_t;

  function automatic vec_t mk(logic rstn, logic fs, logic [10:0] cnt, logic rd, logic empty,
                              logic ack, logic done, logic flush, logic req, logic bsy,
                              logic [21:0] addr, logic [8:0] len, logic [15:0] ucnt);
    vec_t v;
    v.rstn = rstn; v.fs = fs; v.cnt = cnt; v.rd = rd; v.empty = empty; v.ack = ack;
    v.done = done; v.flush = flush; v.req = req; v.bsy = bsy; v.addr = addr;
    v.len = len; v.ucnt = ucnt;
    return v;
  endfunction

  localparam int NV = 28;
  vec_t vt [NV];

  // block A state
  int nb_a, exp_a, infl_a, wait_a, fcnt, done_c;
  // block B state
  int nb_s, exp_s, len_s, infl_s;

  initial begin
    //         rstn fs cnt  rd em ak dn | fl rq by addr len uc
    vt[0]  = mk(0, 0,    0, 0, 0, 0, 0,   0, 0, 0,   0,   0, 0);  // reset
    vt[1]  = mk(1, 1,    0, 0, 0, 0, 0,   1, 0, 1,   0,   0, 0);  // IDLE -> FLUSH
    vt[2]  = mk(1, 0,  769, 0, 0, 0, 0,   0, 0, 1,   0,   0, 0);  // -> CHECK
    vt[3]  = mk(1, 0,  769, 0, 0, 0, 0,   0, 0, 1,   0,   0, 0);  // no credit
    vt[4]  = mk(1, 0,  769, 0, 0, 0, 0,   0, 0, 1,   0,   0, 0);
    vt[5]  = mk(1, 0,  768, 0, 0, 0, 0,   0, 1, 1,   0, 256, 0);  // credit at 768
    vt[6]  = mk(1, 0,  768, 0, 0, 0, 0,   0, 1, 1,   0, 256, 0);  // hold until ack
    vt[7]  = mk(1, 0,  768, 0, 0, 1, 0,   0, 0, 1,   0, 256, 0);  // ack
    vt[8]  = mk(1, 0,  768, 0, 0, 0, 0,   0, 0, 1,   0, 256, 0);
    vt[9]  = mk(1, 0,  768, 0, 0, 0, 1,   0, 0, 1, 256, 256, 0);  // done, addr advances
    vt[10] = mk(1, 0,  768, 0, 0, 0, 0,   0, 1, 1, 256, 256, 0);
    vt[11] = mk(1, 1,    0, 0, 0, 1, 0,   1, 0, 1, 256, 256, 0);  // abort in REQ, ack ignored
    vt[12] = mk(1, 0,    0, 0, 0, 0, 0,   0, 0, 1,   0, 256, 0);  // rearmed at base
    vt[13] = mk(1, 0,    0, 0, 0, 0, 0,   0, 1, 1,   0, 256, 0);
    vt[14] = mk(1, 0,    0, 0, 0, 1, 0,   0, 0, 1,   0, 256, 0);
    vt[15] = mk(1, 1,    0, 0, 0, 0, 0,   0, 0, 1,   0, 256, 0);  // fs in WAIT_DONE: no flush
    vt[16] = mk(1, 0,    0, 0, 0, 0, 0,   0, 0, 1,   0, 256, 0);
    vt[17] = mk(1, 0,    0, 0, 0, 0, 1,   1, 0, 1, 256, 256, 0);  // done -> FLUSH
    vt[18] = mk(1, 0,    0, 0, 0, 0, 0,   0, 0, 1,   0, 256, 0);
    vt[19] = mk(1, 0,    0, 0, 0, 0, 0,   0, 1, 1,   0, 256, 0);
    vt[20] = mk(1, 0,    0, 0, 0, 1, 0,   0, 0, 1,   0, 256, 0);
    vt[21] = mk(1, 1,    0, 0, 0, 0, 1,   1, 0, 1, 256, 256, 0);  // fs with done
    vt[22] = mk(1, 0, 1000, 0, 0, 0, 0,   0, 0, 1,   0, 256, 0);
    vt[23] = mk(1, 0, 1000, 1, 1, 0, 0,   0, 0, 1,   0, 256, 1);  // underflow events
    vt[24] = mk(1, 0, 1000, 1, 0, 0, 0,   0, 0, 1,   0, 256, 1);
    vt[25] = mk(1, 0, 1000, 1, 1, 0, 0,   0, 0, 1,   0, 256, 2);
    vt[26] = mk(1, 0, 1000, 0, 1, 0, 0,   0, 0, 1,   0, 256, 2);
    vt[27] = mk(1, 0, 1000, 1, 1, 0, 0,   0, 0, 1,   0, 256, 3);
    bus.rd_ack = 1'b0; bus.rd_done = 1'b0;
    bus_s.rd_ack = 1'b0; bus_s.rd_done = 1'b0;

    fork
      begin : block_a
        for (int i = 0; i < NV; i++) begin
          @(negedge CLK);
          RSTn = vt[i].rstn; frame_start = vt[i].fs; fifo_wr_cnt = vt[i].cnt;
          fifo_rd = vt[i].rd; fifo_empty = vt[i].empty;
          bus.rd_ack = vt[i].ack; bus.rd_done = vt[i].done;
          @(posedge CLK); #1;
          $display("vec %0d: flush=%0b req=%0b busy=%0b addr=%0h len=%0d ucnt=%0d",
                   i, fifo_flush, bus.rd_req, busy, bus.rd_addr, bus.rd_len, underflow_cnt);
          chk($sformatf("v%0d.flush", i), 32'(fifo_flush), 32'(vt[i].flush));
          chk($sformatf("v%0d.req", i), 32'(bus.rd_req), 32'(vt[i].req));
          chk($sformatf("v%0d.busy", i), 32'(busy), 32'(vt[i].bsy));
          chk($sformatf("v%0d.addr", i), 32'(bus.rd_addr), 32'(vt[i].addr));
          chk($sformatf("v%0d.len", i), 32'(bus.rd_len), 32'(vt[i].len));
          chk($sformatf("v%0d.ucnt", i), 32'(underflow_cnt), 32'(vt[i].ucnt));
        end

        // full 1024x720 frame from CHECK; FIFO drains 48 words per cycle
        frame_start = 1'b0; fifo_rd = 1'b0; fifo_empty = 1'b0;
        nb_a = 0; exp_a = 0; infl_a = 0; wait_a = 0; fcnt = 0; done_c = -10;
        for (int c = 0; c < 40000 && nb_a < 2880; c++) begin
          @(negedge CLK);
          bus.rd_ack = 1'b0; bus.rd_done = 1'b0;
          if (infl_a != 0) begin
            chk("one_outstanding", 32'(bus.rd_req), 32'd0);
            if (wait_a == 0) begin
              bus.rd_done = 1'b1; infl_a = 0; nb_a++; exp_a += 256; fcnt += 256; done_c = c;
            end else begin
              wait_a--;
            end
          end else if (bus.rd_req) begin
            $display("burst %0d: addr=%0h len=%0d", nb_a, bus.rd_addr, bus.rd_len);
            chk("burst_addr", 32'(bus.rd_addr), 32'(exp_a));
            chk("burst_len", 32'(bus.rd_len), 32'd256);
            chk("req_gap", 32'((c - done_c) >= 2), 32'd1);
            bus.rd_ack = 1'b1; infl_a = 1;
            wait_a = (nb_a < 4) ? 19 : 0;
          end
          fifo_wr_cnt = 11'(fcnt);
          fcnt = (fcnt > 48) ? fcnt - 48 : 0;
        end
        chk("frame_bursts", 32'(nb_a), 32'd2880);
        @(negedge CLK);
        bus.rd_done = 1'b0;
        for (int k = 0; k < 10 && busy; k++) @(negedge CLK);
        chk("frame_done_busy", 32'(busy), 32'd0);
        chk("frame_end_addr", 32'(bus.rd_addr), 32'd737280);
        repeat (3) @(negedge CLK);
        chk("frame_done_no_req", 32'(bus.rd_req), 32'd0);
      end

      begin : block_b
        repeat (2) @(negedge CLK);
        chk("s_reset_busy", 32'(busy_s), 32'd0);
        chk("s_reset_req", 32'(bus_s.rd_req), 32'd0);
        chk("s_reset_flush", 32'(fifo_flush_s), 32'd0);
        RSTn_s = 1'b1; frame_start_s = 1'b1;
        @(negedge CLK);
        frame_start_s = 1'b0;
        // 300-word frame: expect 256 then 44
        nb_s = 0; exp_s = 0; infl_s = 0;
        for (int c = 0; c < 200 && nb_s < 2; c++) begin
          @(negedge CLK);
          bus_s.rd_ack = 1'b0; bus_s.rd_done = 1'b0;
          if (infl_s != 0) begin
            bus_s.rd_done = 1'b1; infl_s = 0; nb_s++;
          end else if (bus_s.rd_req) begin
            len_s = (nb_s == 0) ? 256 : 44;
            $display("short-frame burst %0d: addr=%0h len=%0d", nb_s, bus_s.rd_addr, bus_s.rd_len);
            chk("s_burst_addr", 32'(bus_s.rd_addr), 32'(exp_s));
            chk("s_burst_len", 32'(bus_s.rd_len), 32'(len_s));
            exp_s += len_s;
            bus_s.rd_ack = 1'b1; infl_s = 1;
          end
        end
        chk("s_bursts", 32'(nb_s), 32'd2);
        @(negedge CLK);
        bus_s.rd_done = 1'b0;
        for (int k = 0; k < 10 && busy_s; k++) @(negedge CLK);
        chk("s_done_busy", 32'(busy_s), 32'd0);
        chk("s_end_addr", 32'(bus_s.rd_addr), 32'd300);
        repeat (3) @(negedge CLK);
        chk("s_done_no_req", 32'(bus_s.rd_req), 32'd0);

`ifdef DISP_DOUBLE_BUFFER_EN
        wr_frame_done_s = 1'b1;
        @(negedge CLK);
        wr_frame_done_s = 1'b0; frame_start_s = 1'b1;
        @(negedge CLK);
        frame_start_s = 1'b0;
        @(negedge CLK);
        $display("dbuf frame 1: sel=%0b addr=%0h", rd_buf_sel_s, bus_s.rd_addr);
        chk("dbuf_sel", 32'(rd_buf_sel_s), 32'd1);
        chk("dbuf_addr1", 32'(bus_s.rd_addr), 32'h100000);
        frame_start_s = 1'b1;
        @(negedge CLK);
        frame_start_s = 1'b0;
        @(negedge CLK);
        $display("dbuf frame 2: sel=%0b addr=%0h", rd_buf_sel_s, bus_s.rd_addr);
        chk("dbuf_addr2", 32'(bus_s.rd_addr), 32'h100000);
`endif

        // underflow counter: three events, then drive to saturation
        fifo_empty_s = 1'b1; fifo_rd_s = 1'b1;
        repeat (3) @(negedge CLK);
        fifo_rd_s = 1'b0;
        $display("underflow after 3 events: %0d", underflow_cnt_s);
        chk("ucnt_3", 32'(underflow_cnt_s), 32'd3);
        fifo_rd_s = 1'b1;
        repeat (65532) @(negedge CLK);
        fifo_rd_s = 1'b0;
        chk("ucnt_max", 32'(underflow_cnt_s), 32'hFFFF);
        fifo_rd_s = 1'b1;
        @(negedge CLK);
        fifo_rd_s = 1'b0;
        @(negedge CLK);
        $display("underflow after saturation: %0h", underflow_cnt_s);
        chk("ucnt_sat", 32'(underflow_cnt_s), 32'hFFFF);
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
